// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: serialises bytes into 2-bit QAM symbols held SPS samples each, with LUT phase.
// Define QAM_PREAMBLE_EN to prepend PRE_SYMS alternating 11/00 symbols to each frame started from IDLE.
module qam_symbol_scheduler #(
    parameter int SPS      = 8,
    parameter int LUT_AW   = 5,
    parameter int PRE_SYMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              clr_err,
    output logic [1:0]        sym_out,
    output logic              sym_valid,
    output logic [LUT_AW-1:0] phase_idx,
    output logic              busy,
    output logic              underrun
);
    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        UNDERRUN
`ifdef QAM_PREAMBLE_EN
        , PRE
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] sample_cnt;
    logic [1:0]    sym_idx;
    logic [7:0]    hold;
    logic          hold_last;
    logic          sym_end;
    logic          byte_end;
    logic          take;
    logic          set_err;
    logic [1:0]    nxt_idx;
`ifdef QAM_PREAMBLE_EN
    localparam int PW = $clog2(PRE_SYMS + 1);
    logic [PW-1:0] pre_cnt;
`endif

    always_comb begin
        sym_end    = sample_cnt == LAST;
        byte_end   = state == SEND && sym_end && sym_idx == 2'd3;
        nxt_idx    = sym_idx + 2'd1;
        byte_ready = rst && (state == IDLE || state == UNDERRUN || (byte_end && !hold_last));
        take       = byte_valid && byte_ready;
        set_err    = byte_end && !hold_last && !take;
        busy       = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sym_out    <= '0;
            sym_valid  <= 1'b0;
            phase_idx  <= '0;
            sample_cnt <= '0;
            sym_idx    <= '0;
            hold       <= '0;
            hold_last  <= 1'b0;
            underrun   <= 1'b0;
`ifdef QAM_PREAMBLE_EN
            pre_cnt    <= '0;
`endif
        end else begin
            phase_idx <= (state == IDLE) ? (take ? '0 : phase_idx) : phase_idx + 1'b1;
            underrun  <= set_err || (underrun && !clr_err);
            if (take) begin
                hold      <= byte_in;
                hold_last <= byte_last;
            end
            case (state)
                IDLE: if (take) begin
                    sym_valid  <= 1'b1;
                    sample_cnt <= '0;
                    sym_idx    <= '0;
`ifdef QAM_PREAMBLE_EN
                    state      <= PRE;
                    sym_out    <= 2'b11;
                    pre_cnt    <= '0;
`else
                    state      <= SEND;
                    sym_out    <= byte_in[7:6];
`endif
                end
                UNDERRUN: if (take) begin
                    state      <= SEND;
                    sym_out    <= byte_in[7:6];
                    sym_valid  <= 1'b1;
                    sample_cnt <= '0;
                    sym_idx    <= '0;
                end
`ifdef QAM_PREAMBLE_EN
                PRE: begin
                    sample_cnt <= sym_end ? '0 : sample_cnt + 1'b1;
                    if (sym_end && pre_cnt == PW'(PRE_SYMS - 1)) begin
                        state   <= SEND;
                        sym_out <= hold[7:6];
                    end else if (sym_end) begin
                        pre_cnt <= pre_cnt + 1'b1;
                        sym_out <= ~sym_out;
                    end
                end
`endif
                SEND: begin
                    sample_cnt <= sym_end ? '0 : sample_cnt + 1'b1;
                    if (sym_end && sym_idx != 2'd3) begin
                        sym_idx <= nxt_idx;
                        sym_out <= hold[{~nxt_idx, 1'b0} +: 2];
                    end else if (sym_end && take) begin
                        sym_idx <= '0;
                        sym_out <= byte_in[7:6];
                    end else if (sym_end) begin
                        sym_idx   <= '0;
                        sym_out   <= '0;
                        sym_valid <= 1'b0;
                        state     <= hold_last ? IDLE : UNDERRUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb_qam_symbol_scheduler: scoreboarded directed test of the QAM symbol scheduler (SPS=4, LUT_AW=3).
module tb_qam_symbol_scheduler;
    localparam int SPS = 4;
    localparam int AW  = 3;
    localparam int PRE = 4;
`ifdef QAM_PREAMBLE_EN
    localparam int EXTRA = PRE * SPS;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_last = 1'b0;
    logic          clr_err = 1'b0;
    logic          byte_ready;
    logic [1:0]    sym_out;
    logic          sym_valid;
    logic [AW-1:0] phase_idx;
    logic          busy;
    logic          underrun;

    qam_symbol_scheduler #(.SPS(SPS), .LUT_AW(AW), .PRE_SYMS(PRE)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_last(byte_last), .byte_ready(byte_ready), .clr_err(clr_err),
        .sym_out(sym_out), .sym_valid(sym_valid), .phase_idx(phase_idx),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [1:0]    exp_q[$];
    int            vcnt = 0;
    int            rises = 0;
    int            rdy_mid = 0;
    logic          mon_en = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_busy = 1'b0;
    logic [AW-1:0] prev_phase = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every live symbol and tracks phase continuity.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (sym_valid) begin
                vcnt++;
                if (!prev_valid) rises++;
                if (byte_ready) rdy_mid++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sym_extra: got %0h want no symbol at %0t", sym_out, $time);
                end else chk("sym_out", sym_out, exp_q.pop_front());
            end
            if (busy && prev_busy) chk("phase_inc", phase_idx, AW'(prev_phase + 1'b1));
            else if (busy) chk("phase_start", phase_idx, 0);
            else if (!prev_busy) chk("phase_hold", phase_idx, prev_phase);
            prev_valid = sym_valid;
            prev_busy  = busy;
            prev_phase = phase_idx;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("byte_ready_wait", byte_ready, 1);
        if (!byte_ready) return;
`ifdef QAM_PREAMBLE_EN
        if (!busy) for (int i = 0; i < PRE * SPS; i++) exp_q.push_back(((i / SPS) % 2) ? 2'b00 : 2'b11);
`endif
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < SPS; k++) exp_q.push_back(b[7-2*s -: 2]);
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic wait_for(input logic want_underrun);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < 300) begin
            @(negedge clk);
            hit = want_underrun ? (busy && !sym_valid) : !busy;
            n++;
        end
        chk(want_underrun ? "wait_underrun" : "wait_idle", hit, 1);
    endtask

    task automatic clr_counts();
        vcnt    = 0;
        rises   = 0;
        rdy_mid = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_out", sym_out, 0);
        chk("rst_phase", phase_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", byte_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", byte_ready, 1);
        mon_en = 1'b1;

        clr_counts();
        send_byte(8'hB4, 1'b1);
        wait_for(1'b0);
        chk("t1_vcnt", vcnt, 16 + EXTRA);
        chk("t1_rises", rises, 1);
        chk("t1_sym_out_idle", sym_out, 0);
        chk("t1_queue", exp_q.size(), 0);

        clr_counts();
        send_byte(8'h1B, 1'b0);
        send_byte(8'hE4, 1'b1);
        wait_for(1'b0);
        chk("t2_vcnt", vcnt, 32 + EXTRA);
        chk("t2_rises", rises, 1);
        chk("t2_ready_pulses", rdy_mid, 1);
        chk("t2_queue", exp_q.size(), 0);

        clr_counts();
        send_byte(8'hFF, 1'b0);
        wait_for(1'b1);
        chk("t3_underrun", underrun, 1);
        chk("t3_sym_valid", sym_valid, 0);
        chk("t3_sym_out", sym_out, 0);
        chk("t3_vcnt", vcnt, 16 + EXTRA);
        repeat (10) @(negedge clk);
        chk("t3_underrun_held", underrun, 1);
        chk("t3_ready_in_underrun", byte_ready, 1);
        send_byte(8'h9C, 1'b1);
        wait_for(1'b0);
        chk("t3_underrun_sticky", underrun, 1);
        chk("t3_queue", exp_q.size(), 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("t3_clr_err", underrun, 0);

        clr_err = 1'b1;
        send_byte(8'h77, 1'b0);
        wait_for(1'b1);
        chk("t4_set_wins", underrun, 1);
        @(negedge clk);
        chk("t4_clear_next", underrun, 0);
        clr_err = 1'b0;

        send_byte(8'hA5, 1'b1);
        repeat (2 * SPS + 1) @(negedge clk);
        chk("t5_mid_frame", sym_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("t5_sym_valid", sym_valid, 0);
        chk("t5_sym_out", sym_out, 0);
        chk("t5_phase", phase_idx, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", byte_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", byte_ready, 1);

        clr_counts();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        wait_for(1'b0);
        chk("t6_vcnt", vcnt, 48 + EXTRA);
        chk("t6_rises", rises, 1);
        repeat (6) @(negedge clk);
        chk("t6_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
